// File: rtl/fft_stage_ctrl.sv
// Address/handshake controller for one radix-2 DIT FFT stage: sequences butterfly reads,
// tags the butterfly pipeline and steers writeback. Optional stall counter: FFT_STAGE_CTRL_STATS_EN.
module fft_stage_ctrl #(
    parameter int LOG_N  = 6,
    parameter int RD_LAT = 2,
    parameter int WIDTH  = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [$clog2(LOG_N > 1 ? LOG_N : 2)-1:0] stage,
    input  logic                                   hold,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   error,
    output logic                                   rd_en,
    output logic [LOG_N-1:0]                       rd_addr_a,
    output logic [LOG_N-1:0]                       rd_addr_b,
    output logic [LOG_N-2:0]                       tw_addr,
    output logic                                   bf_x_nd,
    output logic [LOG_N-1:0]                       bf_m_in,
    input  logic                                   bf_y_nd,
    input  logic [LOG_N-1:0]                       bf_m_out,
    input  logic                                   bf_error,
    output logic                                   wr_en,
    output logic [LOG_N-1:0]                       wr_addr_a,
    output logic [LOG_N-1:0]                       wr_addr_b
`ifdef FFT_STAGE_CTRL_STATS_EN
    ,
    output logic [15:0]                            stall_cycles
`endif
);

    localparam int SW = $clog2(LOG_N > 1 ? LOG_N : 2);
    localparam logic [SW:0]      LOG_N_V = (SW+1)'(LOG_N);
    localparam logic [SW-1:0]    TW_TOP  = SW'(LOG_N - 1);
    localparam logic [LOG_N-2:0] B_LAST  = '1;
    localparam logic [LOG_N-1:0] W_LAST  = LOG_N'((1 << (LOG_N - 1)) - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state_reg, state_next;

    logic [SW-1:0]    s_reg;
    logic [LOG_N-1:0] span_reg;
    logic [LOG_N-2:0] b_reg;
    logic             last_rd_reg;
    logic [LOG_N-1:0] wr_cnt_reg;
    logic [LOG_N-1:0] outst_reg;
    logic             done_reg;
    logic             error_reg;
    logic             wr_en_reg;
    logic [LOG_N-1:0] wr_addr_a_reg;
    logic [LOG_N-1:0] wr_addr_b_reg;
    logic             sr_valid_reg [RD_LAT];
    logic [LOG_N-1:0] sr_tag_reg   [RD_LAT];

    logic             accept;
    logic             bad_start;
    logic             issue;
    logic             stage_ok;

    logic [LOG_N-1:0] pos_mask;
    logic [LOG_N-2:0] pos;
    logic [LOG_N-1:0] base;
    logic [SW-1:0]    shamt;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   if (issue && (b_reg == B_LAST)) state_next = DRAIN;
            DRAIN:   if (wr_en_reg && (wr_cnt_reg == W_LAST)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The done cycle is already IDLE but still counts as busy, so a start there is dropped.
    always_comb begin
        stage_ok  = ({1'b0, stage} < LOG_N_V);
        accept    = (state_reg == IDLE) && !done_reg && start && stage_ok;
        bad_start = (state_reg == IDLE) && !done_reg && start && !stage_ok;
        issue     = (state_reg == ISSUE) && !hold && !last_rd_reg;
        busy      = (state_reg != IDLE) || done_reg;
    end

    // Butterfly b -> addresses; span_reg is 0 out of reset so every address reads 0.
    always_comb begin
        pos_mask  = span_reg - LOG_N'(1);
        pos       = b_reg & pos_mask[LOG_N-2:0];
        base      = ({1'b0, b_reg} & ~pos_mask) << 1;
        rd_addr_a = base | {1'b0, pos};
        rd_addr_b = rd_addr_a + span_reg;
        shamt     = TW_TOP - s_reg;
        tw_addr   = pos << shamt;
    end

    assign rd_en     = issue;
    assign done      = done_reg;
    assign error     = error_reg;
    assign wr_en     = wr_en_reg;
    assign wr_addr_a = wr_addr_a_reg;
    assign wr_addr_b = wr_addr_b_reg;
    assign bf_x_nd   = sr_valid_reg[RD_LAT-1];
    assign bf_m_in   = sr_tag_reg[RD_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg         <= '0;
            span_reg      <= '0;
            b_reg         <= '0;
            last_rd_reg   <= 1'b0;
            wr_cnt_reg    <= '0;
            outst_reg     <= '0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_addr_a_reg <= '0;
            wr_addr_b_reg <= '0;
        end else begin
            last_rd_reg <= issue;
            if (issue) begin
                b_reg <= b_reg + (LOG_N-1)'(1);
            end
            if (wr_en_reg) begin
                wr_cnt_reg <= wr_cnt_reg + LOG_N'(1);
            end
            if (accept) begin
                s_reg      <= stage;
                span_reg   <= LOG_N'(1) << stage;
                b_reg      <= '0;
                wr_cnt_reg <= '0;
            end

            wr_en_reg <= bf_y_nd && (state_reg != IDLE);
            if (bf_y_nd && (state_reg != IDLE)) begin
                wr_addr_a_reg <= bf_m_out;
                wr_addr_b_reg <= bf_m_out + span_reg;
            end
            done_reg <= wr_en_reg && (wr_cnt_reg == W_LAST);

            // Simultaneous issue and return leave the count unchanged.
            case ({bf_x_nd, bf_y_nd})
                2'b10:   outst_reg <= outst_reg + LOG_N'(1);
                2'b01:   if (outst_reg != '0) outst_reg <= outst_reg - LOG_N'(1);
                default: outst_reg <= outst_reg;
            endcase

            if (bad_start || bf_error ||
                (bf_y_nd && ((state_reg == IDLE) || (outst_reg == '0)))) begin
                error_reg <= 1'b1;
            end
        end
    end

    // Read-latency alignment: tag and strobe travel together for RD_LAT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_valid_reg[0] <= 1'b0;
            sr_tag_reg[0]   <= '0;
        end else begin
            sr_valid_reg[0] <= issue;
            if (issue) begin
                sr_tag_reg[0] <= rd_addr_a;
            end
        end
    end

    generate
        for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_rd_pipe
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr_valid_reg[gi] <= 1'b0;
                    sr_tag_reg[gi]   <= '0;
                end else begin
                    sr_valid_reg[gi] <= sr_valid_reg[gi-1];
                    sr_tag_reg[gi]   <= sr_tag_reg[gi-1];
                end
            end
        end
    endgenerate

`ifdef FFT_STAGE_CTRL_STATS_EN
    logic [15:0] stall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_reg <= '0;
        end else if (accept) begin
            stall_reg <= '0;
        end else if ((state_reg == ISSUE) && hold && (stall_reg != 16'hFFFF)) begin
            stall_reg <= stall_reg + 16'd1;
        end
    end

    assign stall_cycles = stall_reg;
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl (LOG_N=3, RD_LAT=2) with a latency-3 butterfly model.
module tb_fft_stage_ctrl;
    localparam int LOG_N  = 3;
    localparam int RD_LAT = 2;

    logic       clk = 1'b0;
    logic       rst, start, hold, bf_y_nd, bf_error;
    logic [1:0] stage;
    logic [2:0] bf_m_out;
    logic       busy, done, error, rd_en, bf_x_nd, wr_en;
    logic [2:0] rd_addr_a, rd_addr_b, bf_m_in, wr_addr_a, wr_addr_b;
    logic [1:0] tw_addr;
`ifdef FFT_STAGE_CTRL_STATS_EN
    logic [15:0] stall_cycles;
`endif

    fft_stage_ctrl #(.LOG_N(LOG_N), .RD_LAT(RD_LAT), .WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .stage(stage), .hold(hold),
        .busy(busy), .done(done), .error(error), .rd_en(rd_en),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .bf_x_nd(bf_x_nd), .bf_m_in(bf_m_in), .bf_y_nd(bf_y_nd),
        .bf_m_out(bf_m_out), .bf_error(bf_error), .wr_en(wr_en),
        .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
`ifdef FFT_STAGE_CTRL_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    int rq_a[$], rq_b[$], rq_t[$], xq_m[$], xq_c[$], wq_a[$], wq_b[$];
    int rd_cycs[$];
    int rd_seen = 0, done_seen = 0, first_pending = 0, start_cyc = 0;
    int last_rd_cyc = -100, last_wr_cyc = -100;
    logic inj = 1'b0;
    logic [2:0] inj_m = 3'd0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_evt(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=event required=none (t=%0t)", name, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Hand-computed read pairs and twiddles for N=8.
    task automatic push_stage(input int s);
        int a[4], b[4], t[4];
        case (s)
            0: begin a = '{0, 2, 4, 6}; b = '{1, 3, 5, 7}; t = '{0, 0, 0, 0}; end
            1: begin a = '{0, 1, 4, 5}; b = '{2, 3, 6, 7}; t = '{0, 2, 0, 2}; end
            default: begin a = '{0, 1, 2, 3}; b = '{4, 5, 6, 7}; t = '{0, 1, 2, 3}; end
        endcase
        for (int i = 0; i < 4; i++) begin
            rq_a.push_back(a[i]); rq_b.push_back(b[i]); rq_t.push_back(t[i]);
            xq_m.push_back(a[i]);
            wq_a.push_back(a[i]); wq_b.push_back(b[i]);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_bf_x_nd"}, int'(bf_x_nd), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_addrs"}, int'({rd_addr_a, rd_addr_b, tw_addr, bf_m_in, wr_addr_a, wr_addr_b}), 0);
    endtask

    // Butterfly model: returns each tag 3 cycles after bf_x_nd; flushed by reset.
    initial begin
        logic xs, d1v, d2v;
        logic [2:0] xm, d1m, d2m;
        d1v = 0; d2v = 0; d1m = 0; d2m = 0;
        bf_y_nd = 1'b0; bf_m_out = 3'd0;
        forever begin
            @(negedge clk);
            xs = bf_x_nd; xm = bf_m_in;
            @(posedge clk);
            #2;
            if (rst) begin
                d1v = 0; d2v = 0; bf_y_nd = 1'b0;
            end else begin
                bf_y_nd  = d2v | inj;
                bf_m_out = inj ? inj_m : d2m;
                d2v = d1v; d2m = d1m;
                d1v = xs;  d1m = xm;
            end
        end
    end

    // Monitor: pops expected entries whenever the DUT presents a strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rd_en) begin
                    if (rq_a.size() == 0) fail_evt("rd_unexpected");
                    else begin
                        $display("rd  cyc=%0d a=%0d b=%0d tw=%0d", cyc, rd_addr_a, rd_addr_b, tw_addr);
                        chk("rd_addr_a", int'(rd_addr_a), rq_a.pop_front());
                        chk("rd_addr_b", int'(rd_addr_b), rq_b.pop_front());
                        chk("tw_addr", int'(tw_addr), rq_t.pop_front());
                    end
                    chk("rd_during_hold", int'(hold), 0);
                    if (first_pending != 0) begin
                        chk("first_rd_cycle", cyc, start_cyc + 1);
                        first_pending = 0;
                    end else begin
                        chk("rd_spacing_ok", int'(cyc - last_rd_cyc >= 2), 1);
                    end
                    last_rd_cyc = cyc;
                    rd_seen++;
                    rd_cycs.push_back(cyc);
                    xq_c.push_back(cyc + RD_LAT);
                end
                if (bf_x_nd) begin
                    if (xq_m.size() == 0 || xq_c.size() == 0) fail_evt("bf_x_nd_unexpected");
                    else begin
                        $display("bfx cyc=%0d m=%0d", cyc, bf_m_in);
                        chk("bf_m_in", int'(bf_m_in), xq_m.pop_front());
                        chk("bf_x_nd_cycle", cyc, xq_c.pop_front());
                    end
                end
                if (wr_en) begin
                    if (wq_a.size() == 0) fail_evt("wr_unexpected");
                    else begin
                        $display("wr  cyc=%0d a=%0d b=%0d", cyc, wr_addr_a, wr_addr_b);
                        chk("wr_addr_a", int'(wr_addr_a), wq_a.pop_front());
                        chk("wr_addr_b", int'(wr_addr_b), wq_b.pop_front());
                    end
                    last_wr_cyc = cyc;
                end
                if (done) begin
                    $display("done cyc=%0d", cyc);
                    done_seen++;
                    chk("done_after_last_wr", cyc, last_wr_cyc + 1);
                    chk("writes_left_at_done", wq_a.size(), 0);
                    chk("busy_in_done_cycle", int'(busy), 1);
                end
            end
        end
    end

    task automatic run_stage(input int s, input bit hold_test);
        int n;
        int release_cyc;
        push_stage(s);
        rd_seen = 0; done_seen = 0; first_pending = 1;
        rd_cycs.delete();
        release_cyc = -1;
        stage = 2'(s); start = 1'b1; start_cyc = cyc;
        tick;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        if (hold_test) begin
            n = 0;
            while (rd_seen < 2 && n < 50) begin tick; n++; end
            chk("second_issue_seen", int'(rd_seen >= 2), 1);
            hold = 1'b1;
            repeat (5) tick;
            hold = 1'b0;
            release_cyc = cyc;
        end
        n = 0;
        while (done_seen == 0 && n < 100) begin tick; n++; end
        chk("done_seen", done_seen, 1);
        chk("busy_after_done", int'(busy), 0);
        chk("done_single_pulse", int'(done), 0);
        chk("error_clean_stage", int'(error), 0);
        chk("issue_count", rd_seen, 4);
        chk("reads_left", rq_a.size() + xq_m.size(), 0);
        if (hold_test) begin
            chk("third_issue_at_release", (rd_cycs.size() > 2) ? rd_cycs[2] : -1, release_cyc);
`ifdef FFT_STAGE_CTRL_STATS_EN
            chk("stall_cycles", int'(stall_cycles), 5);
`endif
        end
        $display("stage %0d complete", s);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        tick;
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; hold = 1'b0; stage = 2'd0; bf_error = 1'b0;
        repeat (3) tick;
        chk_idle("reset");
        rst = 1'b0;
        tick;
        chk_idle("after_reset");

        run_stage(0, 1'b0);
        run_stage(1, 1'b0);
        run_stage(2, 1'b0);
        run_stage(0, 1'b1);

        // Out-of-range stage: error, never busy.
        do_reset;
        stage = 2'd3; start = 1'b1;
        tick;
        start = 1'b0;
        chk("bad_stage_error", int'(error), 1);
        chk("bad_stage_busy", int'(busy), 0);
        repeat (2) tick;
        chk("bad_stage_busy_later", int'(busy), 0);
        $display("bad stage start checked");

        // Return strobe while IDLE: sticky error, no writeback.
        do_reset;
        chk("pre_inject_error", int'(error), 0);
        inj_m = 3'd5; inj = 1'b1;
        tick;
        inj = 1'b0;
        tick;
        chk("idle_y_error", int'(error), 1);
        chk("idle_y_no_wr", int'(wr_en), 0);
        repeat (3) tick;
        chk("error_sticky", int'(error), 1);
        $display("idle return checked");

        // Asynchronous reset in the middle of a stage.
        do_reset;
        push_stage(0);
        rd_seen = 0; done_seen = 0; first_pending = 1;
        stage = 2'd0; start = 1'b1; start_cyc = cyc;
        tick;
        start = 1'b0;
        n = 0;
        while (rd_seen < 2 && n < 50) begin tick; n++; end
        chk("mid_two_issues", int'(rd_seen >= 2), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async_reset");
        rq_a.delete(); rq_b.delete(); rq_t.delete();
        xq_m.delete(); xq_c.delete(); wq_a.delete(); wq_b.delete();
        @(posedge clk);
        #1;
        tick;
        rst = 1'b0;
        tick;
        run_stage(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fft_stage_ctrl.md
FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 SHALL have parameter LOG_N, default 6: log2 of FFT length N (N = 2^LOG_N).
REQ-002 SHALL have parameter RD_LAT, default 2: sample memory read latency in cycles (>=1).
REQ-003 SHALL have parameter WIDTH, default 32: complex sample width (re/im WIDTH/2 each); used only for pass-through ports.
REQ-004 SHALL have ports: clk  in  1  clock; single clock domain, all logic on rising edge.
REQ-005 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: start  in  1  begin one stage; stage  in  ceil(log2 LOG_N)  stage index s, sampled with start; hold  in  1  inhibit new butterfly issue.
REQ-007 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; error  out  1  sticky fault flag.
REQ-008 SHALL have ports: rd_en  out  1; rd_addr_a, rd_addr_b  out  LOG_N  sample reads; tw_addr  out  LOG_N-1  twiddle ROM read.
REQ-009 SHALL have ports: bf_x_nd  out  1; bf_m_in  out  LOG_N  tag to butterfly; bf_y_nd  in  1; bf_m_out  in  LOG_N  returned tag; bf_error  in  1.
REQ-010 SHALL have ports: wr_en  out  1; wr_addr_a, wr_addr_b  out  LOG_N  writeback addresses for butterfly outputs ya/yb.

Function
REQ-011 SHALL implement states IDLE, ISSUE, DRAIN; IDLE->ISSUE on start with stage<LOG_N; ISSUE->DRAIN after N/2-th rd_en; DRAIN->IDLE when write count reaches N/2.
REQ-012 SHALL latch s and span=2^s on accepted start; start while busy SHALL be ignored.
REQ-013 SHALL, on start with stage>=LOG_N, set error and remain IDLE.
REQ-014 SHALL, for butterfly index b=0..N/2-1 in increasing order: pos=b mod span, grp=b/span, rd_addr_a=grp*2*span+pos, rd_addr_b=rd_addr_a+span, tw_addr=pos<<(LOG_N-1-s).
REQ-015 SHALL assert rd_en first in the cycle after start accepted, then at most once every 2 cycles (butterfly input rate limit), and never in a cycle where hold=1.
REQ-016 SHALL, after hold deasserts, issue on the first cycle with hold=0 provided >=2 cycles since previous rd_en.
REQ-017 SHALL assert bf_x_nd exactly RD_LAT cycles after each rd_en, with bf_m_in=that rd_addr_a (RD_LAT-deep shift register).
REQ-018 SHALL, on bf_y_nd, register wr_en=1, wr_addr_a=bf_m_out, wr_addr_b=bf_m_out+span on the next cycle (latency 1).
REQ-019 SHALL count writes (LOG_N bits, no wrap before N/2); done pulses the cycle after the N/2-th wr_en; busy high from cycle after start accepted through the done cycle, low afterwards.
REQ-020 SHALL set error on bf_y_nd when outstanding (issued minus returned) is zero, on bf_y_nd in IDLE, or on bf_error=1; error clears only by reset.
REQ-021 SHALL, on simultaneous bf_x_nd issue and bf_y_nd, update outstanding count by net zero.
REQ-022 SHALL, on bf_y_nd asserted in the same cycle as bf_x_nd, accept both; bf_y_nd in IDLE SHALL NOT generate wr_en.

Reset
REQ-023 SHALL, on rst=1 (asynchronous, any state incl. mid-stage), force IDLE and clear busy, done, error, rd_en, bf_x_nd, wr_en, counters, shift register; address outputs reset to 0.
REQ-024 SHALL accept start no earlier than the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL support macro FFT_STAGE_CTRL_STATS_EN: when defined, adds output stall_cycles (16 bits), count of ISSUE-state cycles with hold=1, cleared on accepted start, saturating at 16'hFFFF; when undefined, port and counter are absent and behaviour otherwise identical.

Verification
REQ-026 LOG_N=3, RD_LAT=2, start stage=0, hold=0 -> rd pairs (0,1),(2,3),(4,5),(6,7) on alternate cycles, tw_addr 0 each; bf_x_nd 2 cycles after each rd_en.
REQ-027 LOG_N=3, stage=1 -> pairs (0,2),(1,3),(4,6),(5,7), tw_addr 0,2,0,2; stage=2 -> (0,4),(1,5),(2,6),(3,7), tw_addr 0,1,2,3.
REQ-028 Model butterfly latency 3 returning m: 4 wr_en with wr_addr matching read pairs; done single pulse cycle after 4th wr_en; busy low next cycle.
REQ-029 hold=1 for 5 cycles after 2nd issue -> no rd_en during hold, 3rd issue first cycle hold=0; with STATS_EN stall_cycles=5.
REQ-030 Inject bf_y_nd in IDLE -> error=1 sticky, no wr_en; start with stage=3 (LOG_N=3) -> error=1, busy stays 0.
REQ-031 rst pulse mid-stage after 2 issues -> all outputs 0 immediately (asynchronous); subsequent start stage=0 runs full clean sequence.
